reg_bus_master: RTL and testbench
=================================

// Module: reg_bus_master
// PURPOSE
//  Initiator side of the board register-file bus (reg_raddr/reg_rdata/reg_waddr/reg_wdata/reg_wen).
//  Accepts single-quadlet write or N-quadlet block-read commands from a host-side packet engine,
//  drives the bus with the register file's timing, and returns read data on a valid/ready stream.
//  Sits between the FireWire/Ethernet command parser and BoardRegs plus the per-channel register files.
// PARAMETERS
//  RD_LATENCY  2   sysclk cycles from reg_raddr driven to reg_rdata valid (min 1)
//  WEN_CYCLES  1   cycles reg_wen stays high per write (min 1)
// PORTS
//  sysclk      in   1   system clock; all logic on rising edge
//  reset       in   1   asynchronous, active-high reset
//  cmd_valid   in   1   command present
//  cmd_ready   out  1   command accepted when cmd_valid & cmd_ready
//  cmd_write   in   1   1 = single-quadlet write, 0 = block read
//  cmd_addr    in   16  start register address
//  cmd_wdata   in   32  write data (cmd_write=1 only)
//  cmd_count   in   8   block-read quadlet count; 0 means 256
//  abort       in   1   abandon current block read
//  reg_raddr   out  16  register read address
//  reg_rdata   in   32  register read data
//  reg_waddr   out  16  register write address
//  reg_wdata   out  32  register write data
//  reg_wen     out  1   write enable
//  rsp_valid   out  1   read quadlet available
//  rsp_ready   in   1   consumer accepts quadlet when rsp_valid & rsp_ready
//  rsp_data    out  32  read quadlet
//  rsp_last    out  1   marks final quadlet of a block
//  busy        out  1   high in any state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0; cmd_ready=1 only in IDLE, so 0 during reset, 1 on first cycle after release.
//  States: IDLE, WRITE, RD_ADDR, RD_WAIT, RD_PUSH.
//  IDLE: cmd_ready=1. On accept, latch addr/wdata/count (0 -> 256 in a 9-bit counter).
//    cmd_write=1 -> WRITE; else -> RD_ADDR.
//  WRITE: reg_waddr/reg_wdata driven from latched values on the cycle after accept; reg_wen high for
//    exactly WEN_CYCLES consecutive cycles, addr/data stable throughout and one cycle after; then IDLE.
//    No rsp beat for writes. abort ignored in WRITE (a write is never truncated).
//  RD_ADDR: drive reg_raddr=current addr (held stable until next RD_ADDR); load wait counter with
//    RD_LATENCY; -> RD_WAIT.
//  RD_WAIT: decrement; when counter expires sample reg_rdata into rsp_data register; -> RD_PUSH.
//    Latency: cmd accept at cycle 0 -> reg_raddr at cycle 1 -> rsp_valid at cycle 2+RD_LATENCY.
//  RD_PUSH: rsp_valid=1, rsp_data/rsp_last held stable until handshake (backpressure unbounded).
//    rsp_last=1 iff remaining count==1. On handshake: count-1, addr+1;
//    count now 0 -> IDLE, else -> RD_ADDR. Sustained rate: one quadlet per RD_LATENCY+2 cycles.
//  Address arithmetic: 16-bit unsigned, 0xFFFF+1 wraps to 0x0000; no carry into other fields.
//  reg_wen held 0 in all read states; reg_raddr is don't-care-but-stable outside RD_* states (holds last).
//  abort (sampled high in RD_ADDR/RD_WAIT/RD_PUSH): go to IDLE next cycle; rsp_valid drops without
//    handshake; no further rsp beats; a beat completing handshake in the same cycle as abort counts.
//  cmd_valid while busy: ignored (cmd_ready=0); command must be held by the requester.
//  Reset asserted mid-operation: immediately to IDLE, reg_wen=0, rsp_valid=0, counters cleared.
// TESTING
//  1. Write addr 0x0003 data 0x000FFFF0, WEN_CYCLES=1 -> reg_wen high 1 cycle, waddr=0x0003, wdata held; no rsp.
//  2. Block read addr 0x0000 count 4, model rdata=addr*0x11, rsp_ready=1 -> 4 beats 0x00,0x11,0x22,0x33,
//     last on 4th; first rsp_valid exactly 4 cycles after accept (RD_LATENCY=2).
//  3. Same read with rsp_ready low 10 cycles on beat 2 -> rsp_data stable, reg_raddr not advanced, no loss.
//  4. Read addr 0xFFFE count 3 -> raddr sequence 0xFFFE,0xFFFF,0x0000; cmd_count=0 -> 256 beats, last on 256th.
//  5. abort during RD_WAIT of beat 2 of 8 -> 1 beat delivered, IDLE next cycle, cmd_ready=1, no rsp_last.
//  6. reset pulse mid-write (reg_wen high, WEN_CYCLES=4) -> reg_wen=0 immediately; new cmd accepted after release.

Source files
------------

// File: rtl/reg_bus_master.sv
// reg_bus_master
// Initiator for the board register-file bus. Takes single-quadlet write or
// N-quadlet block-read commands from the host packet engine, drives the
// register bus with the register file's read latency and write-enable width,
// and returns read quadlets on a valid/ready stream.
//
// Ports
//   sysclk, reset                 clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_write, cmd_addr,
//   cmd_wdata, cmd_count          command fields (count 0 means 256)
//   abort                         abandon the current block read
//   reg_raddr, reg_rdata          register read port
//   reg_waddr, reg_wdata, reg_wen register write port
//   rsp_valid/rsp_ready,
//   rsp_data, rsp_last            read-data stream
//   busy                          high whenever not idle
module reg_bus_master #(
  parameter int RD_LATENCY = 2,
  parameter int WEN_CYCLES = 1
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [7:0]  cmd_count,
  input  logic        abort,
  output logic [15:0] reg_raddr,
  input  logic [31:0] reg_rdata,
  output logic [15:0] reg_waddr,
  output logic [31:0] reg_wdata,
  output logic        reg_wen,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        busy
);

  localparam int LAT_W = $clog2(RD_LATENCY + 1);
  localparam int WEN_W = $clog2(WEN_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_ADDR = 3'd2,
    RD_WAIT = 3'd3,
    RD_PUSH = 3'd4
  } state_t;

  state_t             state_q;
  logic [15:0]        addr_q;
  logic [8:0]         cnt_q;      // remaining quadlets, 1..256
  logic [LAT_W-1:0]   wait_q;
  logic [WEN_W-1:0]   wen_cnt_q;
  logic               cmd_ready_q;
  logic               busy_q;
  logic [15:0]        reg_raddr_q;
  logic [15:0]        reg_waddr_q;
  logic [31:0]        reg_wdata_q;
  logic               reg_wen_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_data_q;
  logic               rsp_last_q;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      wait_q      <= '0;
      wen_cnt_q   <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      reg_raddr_q <= '0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
      reg_wen_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // cmd_ready comes up on the first edge after reset release
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            addr_q      <= cmd_addr;
            cnt_q       <= (cmd_count == 8'd0) ? 9'd256 : {1'b0, cmd_count};
            if (cmd_write) begin
              reg_waddr_q <= cmd_addr;
              reg_wdata_q <= cmd_wdata;
              reg_wen_q   <= 1'b1;
              wen_cnt_q   <= WEN_W'(WEN_CYCLES);
              state_q     <= WRITE;
            end else begin
              // address is on the bus during the RD_ADDR cycle itself
              reg_raddr_q <= cmd_addr;
              state_q     <= RD_ADDR;
            end
          end
        end

        WRITE: begin
          // abort is deliberately not looked at: writes always complete
          if (wen_cnt_q == WEN_W'(1)) begin
            reg_wen_q   <= 1'b0;
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            wen_cnt_q <= wen_cnt_q - WEN_W'(1);
          end
        end

        RD_ADDR: begin
          if (abort) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            wait_q  <= LAT_W'(RD_LATENCY);
            state_q <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (abort) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else if (wait_q == LAT_W'(1)) begin
            rsp_data_q  <= reg_rdata;
            rsp_last_q  <= (cnt_q == 9'd1);
            rsp_valid_q <= 1'b1;
            state_q     <= RD_PUSH;
          end else begin
            wait_q <= wait_q - LAT_W'(1);
          end
        end

        RD_PUSH: begin
          if (rsp_ready) begin
            // a beat accepted in the abort cycle still counts as delivered
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            cnt_q       <= cnt_q - 9'd1;
            addr_q      <= addr_q + 16'd1;
            if ((cnt_q == 9'd1) || abort) begin
              state_q     <= IDLE;
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              reg_raddr_q <= addr_q + 16'd1;
              state_q     <= RD_ADDR;
            end
          end else if (abort) begin
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b0;
          busy_q      <= 1'b0;
          reg_wen_q   <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign reg_raddr = reg_raddr_q;
  assign reg_waddr = reg_waddr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wen   = reg_wen_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Testbench for reg_bus_master. A register-file model returns addr*0x11 with
// a two-cycle read latency; expected read beats are queued by the stimulus
// and a monitor on the falling edge pops and compares every accepted beat.
// A second instance with a four-cycle write enable covers reset mid-write.
module tb_reg_bus_master;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [7:0]  cmd_count;
  logic        abort_s;
  logic [15:0] reg_raddr, reg_waddr;
  logic [31:0] reg_rdata, reg_wdata;
  logic        reg_wen;
  logic        rsp_valid, rsp_ready, rsp_last, busy;
  logic [31:0] rsp_data;

  logic        w_reset, w_cmd_valid, w_cmd_ready, w_cmd_write;
  logic [15:0] w_cmd_addr, w_reg_raddr, w_reg_waddr;
  logic [31:0] w_cmd_wdata, w_reg_wdata, w_rsp_data;
  logic [7:0]  w_cmd_count;
  logic        w_reg_wen, w_rsp_valid, w_rsp_last, w_busy;

  logic [31:0] rd_p1 = '0;
  logic [31:0] rd_p2 = '0;

  beat_t exp_q[$];
  int    pass_cnt = 0;
  int    total_cnt = 0;
  int    beats_seen = 0;

  always #5 clk = ~clk;

  reg_bus_master #(.RD_LATENCY(2), .WEN_CYCLES(1)) dut (
    .sysclk(clk), .reset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_count(cmd_count),
    .abort(abort_s),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_wen(reg_wen),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .busy(busy)
  );

  reg_bus_master #(.RD_LATENCY(2), .WEN_CYCLES(4)) dut_w4 (
    .sysclk(clk), .reset(w_reset),
    .cmd_valid(w_cmd_valid), .cmd_ready(w_cmd_ready), .cmd_write(w_cmd_write),
    .cmd_addr(w_cmd_addr), .cmd_wdata(w_cmd_wdata), .cmd_count(w_cmd_count),
    .abort(1'b0),
    .reg_raddr(w_reg_raddr), .reg_rdata(32'h0),
    .reg_waddr(w_reg_waddr), .reg_wdata(w_reg_wdata), .reg_wen(w_reg_wen),
    .rsp_valid(w_rsp_valid), .rsp_ready(1'b1), .rsp_data(w_rsp_data),
    .rsp_last(w_rsp_last), .busy(w_busy)
  );

  // register file: data = addr*0x11, valid two cycles after the address
  always @(posedge clk) begin
    rd_p1 <= {16'h0, reg_raddr} * 32'h11;
    rd_p2 <= rd_p1;
  end
  assign reg_rdata = rd_p2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_bound(input string name);
    total_cnt++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  function automatic logic [31:0] model(input logic [15:0] a);
    return {16'h0, a} * 32'h11;
  endfunction

  task automatic push_read(input logic [15:0] a, input int n);
    logic [15:0] x;
    x = a;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{data: model(x), last: (i == n - 1)});
      x = x + 16'd1;
    end
  endtask

  // returns in the cycle after the accepting edge (posedge + 1)
  task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d,
                       input logic [7:0] c);
    int n;
    @(negedge clk);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_count = c; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      fail_bound("cmd_accept");
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < bound) begin @(negedge clk); n++; end
    if (n >= bound) fail_bound("read_complete");
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("idle_after_read", 32'(busy), 32'd0);
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (beats_seen < target && n < 60) begin @(posedge clk); #1; n++; end
    if (beats_seen < target) fail_bound("beat_wait");
  endtask

  // monitor: compares accepted beats and checks hold-stability under backpressure
  initial begin
    beat_t       e;
    logic        stall_prev;
    logic [31:0] prev_data;
    logic        prev_last;
    stall_prev = 1'b0; prev_data = '0; prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (stall_prev && rsp_valid) begin
          check("hold_data", rsp_data, prev_data);
          check("hold_last", 32'(rsp_last), 32'(prev_last));
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_beat: got data 0x%08h, required no beat at %0t", rsp_data, $time);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", rsp_data, e.data);
            check("beat_last", 32'(rsp_last), 32'(e.last));
          end
          beats_seen++;
        end
        stall_prev = rsp_valid && !rsp_ready;
        prev_data  = rsp_data;
        prev_last  = rsp_last;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    rst = 1'b1; w_reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_count = '0;
    abort_s = 1'b0; rsp_ready = 1'b1;
    w_cmd_valid = 1'b0; w_cmd_write = 1'b0; w_cmd_addr = '0; w_cmd_wdata = '0; w_cmd_count = '0;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wen", 32'(reg_wen), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0; w_reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // single write
    issue(1'b1, 16'h0003, 32'h000FFFF0, 8'd0);
    @(negedge clk);
    check("wr_wen_c1", 32'(reg_wen), 32'd1);
    check("wr_waddr_c1", 32'(reg_waddr), 32'h0003);
    check("wr_wdata_c1", reg_wdata, 32'h000FFFF0);
    check("wr_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("wr_wen_c2", 32'(reg_wen), 32'd0);
    check("wr_waddr_c2", 32'(reg_waddr), 32'h0003);
    check("wr_wdata_c2", reg_wdata, 32'h000FFFF0);
    check("wr_no_rsp", 32'(rsp_valid), 32'd0);
    check("wr_ready_again", 32'(cmd_ready), 32'd1);

    // block read of 4, latency from accept to first beat
    push_read(16'h0000, 4);
    issue(1'b0, 16'h0000, 32'h0, 8'd4);
    @(negedge clk);
    check("rd_raddr_c1", 32'(reg_raddr), 32'h0000);
    check("rd_cmd_ready_busy", 32'(cmd_ready), 32'd0);
    check("rd_wen_low", 32'(reg_wen), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rd_valid_c3", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("rd_valid_c4", 32'(rsp_valid), 32'd1);
    wait_done(100);

    // same read with a 10-cycle stall on beat 2
    base = beats_seen;
    push_read(16'h0000, 4);
    issue(1'b0, 16'h0000, 32'h0, 8'd4);
    wait_beats(base + 1);
    rsp_ready = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    if (!rsp_valid) fail_bound("stall_beat2");
    repeat (9) @(negedge clk);
    check("stall_raddr", 32'(reg_raddr), 32'h0001);
    check("stall_valid", 32'(rsp_valid), 32'd1);
    check("stall_data", rsp_data, 32'h11);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_done(100);

    // address wrap
    push_read(16'hFFFE, 3);
    issue(1'b0, 16'hFFFE, 32'h0, 8'd3);
    wait_done(100);

    // count 0 means 256 beats
    base = beats_seen;
    push_read(16'h0100, 256);
    issue(1'b0, 16'h0100, 32'h0, 8'd0);
    wait_done(1500);
    check("beats_256", 32'(beats_seen - base), 32'd256);

    // abort in RD_WAIT of beat 2 of 8
    base = beats_seen;
    push_read(16'h0020, 1);
    exp_q[0].last = 1'b0;
    issue(1'b0, 16'h0020, 32'h0, 8'd8);
    wait_beats(base + 1);
    @(posedge clk); #1;
    abort_s = 1'b1;
    @(posedge clk); #1;
    abort_s = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_rsp_last", 32'(rsp_last), 32'd0);
    repeat (10) @(negedge clk);
    check("abort_beats", 32'(beats_seen - base), 32'd1);
    check("abort_queue", 32'(exp_q.size()), 32'd0);

    // reset mid-write on the 4-cycle write-enable instance
    @(negedge clk);
    w_cmd_write = 1'b1; w_cmd_addr = 16'h0055; w_cmd_wdata = 32'hA5A5A5A5; w_cmd_valid = 1'b1;
    n = 0;
    while (!w_cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (!w_cmd_ready) fail_bound("w4_accept");
    @(posedge clk); #1;
    w_cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("w4_wen_mid", 32'(w_reg_wen), 32'd1);
    #1 w_reset = 1'b1;
    #1;
    check("w4_rst_wen", 32'(w_reg_wen), 32'd0);
    check("w4_rst_busy", 32'(w_busy), 32'd0);
    check("w4_rst_cmd_ready", 32'(w_cmd_ready), 32'd0);
    @(negedge clk);
    w_reset = 1'b0;
    @(negedge clk);
    check("w4_ready_after_rst", 32'(w_cmd_ready), 32'd1);
    w_cmd_addr = 16'h0077; w_cmd_wdata = 32'h12345678; w_cmd_valid = 1'b1;
    @(posedge clk); #1;
    w_cmd_valid = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (w_reg_wen) n++;
    end
    check("w4_wen_cycles", 32'(n), 32'd4);
    check("w4_waddr", 32'(w_reg_waddr), 32'h0077);
    check("w4_wdata", w_reg_wdata, 32'h12345678);
    check("w4_no_rsp", 32'(w_rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
